shot_sequencer: RTL and testbench

Turn controller for the 4x4 cell grid. It sits between the debounced user inputs (fire button, one-hot row/column selector, row/column mode switch, selector error flag) and the 16 cell instances. It converts each accepted fire press into one sequenced strobe on the cell enables, waits for the cells to settle, then scores the grid. It also tracks the shot budget and declares win or loss.

---
 rtl/shot_sequencer_if.sv | 28 ++
 rtl/shot_sequencer.sv | 161 ++++++++++++++++
 tb/tb_shot_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/shot_sequencer_if.sv
// Bundle between the input checker / cell grid and shot_sequencer.
// master: drives fire_db, row_column, nRow, error, display_state; observes the rest.
// slave:  the sequencer; consumes inputs, drives enables, strobe and status.
interface shot_sequencer_if;
  logic        fire_db;
  logic [3:0]  row_column;
  logic        nRow;
  logic        error;
  logic [31:0] display_state;
  logic [3:0]  row_en;
  logic [3:0]  col_en;
  logic        fire_out;
  logic        busy;
  logic [4:0]  shots_left;
  logic [4:0]  ships_left;
  logic        game_over;
  logic        win;

  modport master (
    output fire_db, row_column, nRow, error, display_state,
    input  row_en, col_en, fire_out, busy, shots_left, ships_left, game_over, win
  );

  modport slave (
    input  fire_db, row_column, nRow, error, display_state,
    output row_en, col_en, fire_out, busy, shots_left, ships_left, game_over, win
  );
endinterface

// File: rtl/shot_sequencer.sv
// Turn controller for the 4x4 cell grid: turns each accepted fire press into
// one enable/strobe sequence, waits for the cells to settle, scores the grid
// and tracks the shot budget and the win/loss result.
// Ports: clk, reset (sync, active-high), bus (slave modport of shot_sequencer_if)
//   in : fire_db, row_column[3:0], nRow, error, display_state[31:0]
//   out: row_en[3:0], col_en[3:0], fire_out, busy, shots_left[4:0],
//        ships_left[4:0], game_over, win (all registered)
module shot_sequencer #(
  parameter int unsigned MAX_SHOTS  = 12,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  shot_sequencer_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SHOT_W = 5;
  localparam int unsigned SHIP_W = 5;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CELLS  = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_SETTLE, S_CHECK, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                fire_q, fire_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    row_en_q, row_en_d;
  logic [SEL_W-1:0]    col_en_q, col_en_d;
  logic                fire_out_q, fire_out_d;
  logic                busy_q, busy_d;
  logic [SHOT_W-1:0]   shots_q, shots_d;
  logic [SHIP_W-1:0]   ships_q, ships_d;
  logic                game_over_q, game_over_d;
  logic                win_q, win_d;

  logic                press_c;
  logic                accept_c;
  logic [SHOT_W-1:0]   shots_dec_c;
  logic [SHIP_W-1:0]   ships_cnt_c;

  // Press detection, selector qualification and saturating budget decrement
  assign fire_d      = bus.fire_db;
  assign press_c     = bus.fire_db & ~fire_q;
  assign accept_c    = press_c & ~bus.error & $onehot(bus.row_column);
  assign shots_dec_c = (shots_q == '0) ? '0 : shots_q - SHOT_W'(1);

  // Number of cells currently holding an unhit ship (01)
  always_comb begin
    ships_cnt_c = '0;
    for (int k = 0; k < CELLS; k++) begin
      if (bus.display_state[2*k +: 2] == 2'b01) ships_cnt_c = ships_cnt_c + SHIP_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; selector/mode are latched only on acceptance
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sel_d   = bus.row_column;
          mode_d  = bus.nRow;
          state_d = S_ARM;
        end
      end
      S_ARM:  state_d = S_FIRE;
      S_FIRE: begin
        cnt_d   = CNT_W'(SETTLE_CYC);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        // Win takes priority over an exhausted budget
        if (ships_q == '0)          state_d = S_DONE;
        else if (shots_dec_c == '0) state_d = S_DONE;
        else                        state_d = S_IDLE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computed from the upcoming state so registered outputs line up with it
  always_comb begin
    row_en_d    = '0;
    col_en_d    = '0;
    fire_out_d  = 1'b0;
    busy_d      = 1'b0;
    game_over_d = 1'b0;
    shots_d     = shots_q;
    win_d       = win_q;
    ships_d     = ships_cnt_c;
    if (state_d == S_ARM || state_d == S_FIRE) begin
      if (mode_d) col_en_d = sel_d;
      else        row_en_d = sel_d;
    end
    fire_out_d  = (state_d == S_FIRE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    game_over_d = (state_d == S_DONE);
    if (state_q == S_CHECK) begin
      shots_d = shots_dec_c;
      win_d   = (ships_q == '0);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q      <= 1'b0;
      sel_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      row_en_q    <= '0;
      col_en_q    <= '0;
      fire_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      shots_q     <= SHOT_W'(MAX_SHOTS);
      ships_q     <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      fire_q      <= fire_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      row_en_q    <= row_en_d;
      col_en_q    <= col_en_d;
      fire_out_q  <= fire_out_d;
      busy_q      <= busy_d;
      shots_q     <= shots_d;
      ships_q     <= ships_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign bus.row_en     = row_en_q;
  assign bus.col_en     = col_en_q;
  assign bus.fire_out   = fire_out_q;
  assign bus.busy       = busy_q;
  assign bus.shots_left = shots_q;
  assign bus.ships_left = ships_q;
  assign bus.game_over  = game_over_q;
  assign bus.win        = win_q;
endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer: instance A (12 shots) and instance B (2 shots).
module tb_shot_sequencer;
  localparam int MAXA = 12;
  localparam int MAXB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        fire_db_v [2];
  logic [3:0]  rc_v      [2];
  logic        nrow_v    [2];
  logic        err_v     [2];
  logic [31:0] disp_v    [2];
  logic [3:0]  row_v     [2];
  logic [3:0]  col_v     [2];
  logic        fo_v      [2];
  logic        busy_v    [2];
  logic        go_v      [2];
  logic        win_v     [2];
  logic [4:0]  shots_v   [2];
  logic [4:0]  ships_v   [2];

  shot_sequencer_if ifa ();
  shot_sequencer_if ifb ();

  assign ifa.fire_db = fire_db_v[0];  assign ifb.fire_db = fire_db_v[1];
  assign ifa.row_column = rc_v[0];    assign ifb.row_column = rc_v[1];
  assign ifa.nRow = nrow_v[0];        assign ifb.nRow = nrow_v[1];
  assign ifa.error = err_v[0];        assign ifb.error = err_v[1];
  assign ifa.display_state = disp_v[0]; assign ifb.display_state = disp_v[1];
  assign row_v[0] = ifa.row_en;       assign row_v[1] = ifb.row_en;
  assign col_v[0] = ifa.col_en;       assign col_v[1] = ifb.col_en;
  assign fo_v[0] = ifa.fire_out;      assign fo_v[1] = ifb.fire_out;
  assign busy_v[0] = ifa.busy;        assign busy_v[1] = ifb.busy;
  assign go_v[0] = ifa.game_over;     assign go_v[1] = ifb.game_over;
  assign win_v[0] = ifa.win;          assign win_v[1] = ifb.win;
  assign shots_v[0] = ifa.shots_left; assign shots_v[1] = ifb.shots_left;
  assign ships_v[0] = ifa.ships_left; assign ships_v[1] = ifb.ships_left;

  shot_sequencer #(.MAX_SHOTS(MAXA), .SETTLE_CYC(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  shot_sequencer #(.MAX_SHOTS(MAXB), .SETTLE_CYC(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int n_vec = 0;
  int n_err = 0;
  int exp_shots [2];
  bit exp_done  [2];
  bit exp_win   [2];
  int          sb_shots [$];
  logic [7:0]  sq_a [$];
  logic [7:0]  sq_b [$];
  logic [7:0]  ea, eb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ships_in(input logic [31:0] d);
    int n = 0;
    for (int k = 0; k < 16; k++) if (d[2*k +: 2] == 2'b01) n++;
    return n;
  endfunction

  // Strobe scoreboards: each strobe must match a queued expectation of {row_en,col_en}
  always @(negedge clk) begin
    if (fo_v[0] === 1'b1) begin
      chk("strobe_expected_a", 32'(sq_a.size() != 0), 32'd1);
      if (sq_a.size() != 0) begin
        ea = sq_a.pop_front();
        chk("strobe_enables_a", 32'({row_v[0], col_v[0]}), 32'(ea));
      end
    end
    if (fo_v[1] === 1'b1) begin
      chk("strobe_expected_b", 32'(sq_b.size() != 0), 32'd1);
      if (sq_b.size() != 0) begin
        eb = sq_b.pop_front();
        chk("strobe_enables_b", 32'({row_v[1], col_v[1]}), 32'(eb));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    exp_shots[0] = MAXA; exp_shots[1] = MAXB;
    exp_done[0] = 1'b0;  exp_done[1] = 1'b0;
    exp_win[0] = 1'b0;   exp_win[1] = 1'b0;
  endtask

  // One press on instance w, then observe the full turn through cycle 6
  task automatic do_turn(input int w, input logic [3:0] rc, input logic nr, input logic er,
                         input logic [31:0] disp_after, input bit repress, input string tag);
    bit acc;
    int e;
    acc = !er && $onehot(rc) && !exp_done[w];
    if (acc) begin
      exp_shots[w] = (exp_shots[w] > 0) ? exp_shots[w] - 1 : 0;
      if (w == 0) sq_a.push_back(nr ? {4'b0000, rc} : {rc, 4'b0000});
      else        sq_b.push_back(nr ? {4'b0000, rc} : {rc, 4'b0000});
      if (ships_in(disp_after) == 0) begin
        exp_done[w] = 1'b1; exp_win[w] = 1'b1;
      end else if (exp_shots[w] == 0) begin
        exp_done[w] = 1'b1; exp_win[w] = 1'b0;
      end
    end
    sb_shots.push_back(exp_shots[w]);
    rc_v[w] = rc; nrow_v[w] = nr; err_v[w] = er; fire_db_v[w] = 1'b1;
    tick();
    chk({tag, "_c1_busy"}, 32'(busy_v[w]), 32'(acc));
    chk({tag, "_c1_row"}, 32'(row_v[w]), 32'((acc && !nr) ? rc : 4'b0000));
    chk({tag, "_c1_col"}, 32'(col_v[w]), 32'((acc && nr) ? rc : 4'b0000));
    disp_v[w] = disp_after;
    fire_db_v[w] = 1'b0;
    tick();
    chk({tag, "_c2_fire"}, 32'(fo_v[w]), 32'(acc));
    if (repress) fire_db_v[w] = 1'b1;
    tick();
    chk({tag, "_c3_fire"}, 32'(fo_v[w]), 32'd0);
    fire_db_v[w] = 1'b0;
    tick();
    tick();
    tick();
    e = sb_shots.pop_front();
    chk({tag, "_shots"}, 32'(shots_v[w]), 32'(e));
    chk({tag, "_busy"}, 32'(busy_v[w]), 32'd0);
    chk({tag, "_game_over"}, 32'(go_v[w]), 32'(exp_done[w]));
    chk({tag, "_win"}, 32'(win_v[w]), 32'(exp_win[w]));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      fire_db_v[i] = 1'b0; rc_v[i] = 4'b0000; nrow_v[i] = 1'b0; err_v[i] = 1'b0;
    end
    disp_v[0] = 32'h0000_0401;
    disp_v[1] = 32'h0000_0001;

    // Reset values observed while reset is still held
    reset = 1'b1;
    tick();
    tick();
    chk("rst_row_en", 32'(row_v[0]), 32'd0);
    chk("rst_col_en", 32'(col_v[0]), 32'd0);
    chk("rst_fire_out", 32'(fo_v[0]), 32'd0);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_shots_a", 32'(shots_v[0]), 32'(MAXA));
    chk("rst_shots_b", 32'(shots_v[1]), 32'(MAXB));
    chk("rst_ships", 32'(ships_v[0]), 32'd0);
    chk("rst_game_over", 32'(go_v[0]), 32'd0);
    chk("rst_win", 32'(win_v[0]), 32'd0);
    reset = 1'b0;
    tick();
    chk("ships_count", 32'(ships_v[0]), 32'd2);
    exp_shots[0] = MAXA; exp_shots[1] = MAXB;
    exp_done[0] = 1'b0;  exp_done[1] = 1'b0;
    exp_win[0] = 1'b0;   exp_win[1] = 1'b0;

    do_turn(0, 4'b0010, 1'b0, 1'b0, 32'h0000_0401, 1'b0, "row_shot");
    do_turn(0, 4'b0100, 1'b0, 1'b1, 32'h0000_0401, 1'b0, "rej_error");
    do_turn(0, 4'b0110, 1'b0, 1'b0, 32'h0000_0401, 1'b0, "rej_onehot");
    do_turn(0, 4'b0000, 1'b1, 1'b0, 32'h0000_0401, 1'b0, "rej_zero");
    do_turn(0, 4'b1000, 1'b1, 1'b0, 32'h0000_0401, 1'b1, "col_repress");

    // Win: the only ship becomes hit before CHECK
    disp_v[0] = 32'h0000_0001;
    do_reset();
    chk("win_ships_pre", 32'(ships_v[0]), 32'd1);
    do_turn(0, 4'b0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, "win");
    do_turn(0, 4'b0010, 1'b0, 1'b0, 32'h0000_0002, 1'b0, "win_after");

    // Loss: instance B runs out of shots with a ship still afloat
    do_reset();
    do_turn(1, 4'b0001, 1'b0, 1'b0, 32'h0000_0001, 1'b0, "loss1");
    do_turn(1, 4'b0010, 1'b1, 1'b0, 32'h0000_0001, 1'b0, "loss2");
    do_turn(1, 4'b0100, 1'b0, 1'b0, 32'h0000_0001, 1'b0, "loss_after");

    // Mid-turn reset during the FIRE cycle
    disp_v[0] = 32'h0000_0401;
    do_reset();
    rc_v[0] = 4'b0100; nrow_v[0] = 1'b0; err_v[0] = 1'b0;
    sq_a.push_back({4'b0100, 4'b0000});
    fire_db_v[0] = 1'b1;
    tick();
    fire_db_v[0] = 1'b0;
    tick();
    chk("mt_fire", 32'(fo_v[0]), 32'd1);
    reset = 1'b1;
    tick();
    chk("mt_fire_off", 32'(fo_v[0]), 32'd0);
    chk("mt_busy", 32'(busy_v[0]), 32'd0);
    chk("mt_shots", 32'(shots_v[0]), 32'(MAXA));
    chk("mt_row_en", 32'(row_v[0]), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("mt_idle_fire", 32'(fo_v[0]), 32'd0);
    chk("mt_idle_busy", 32'(busy_v[0]), 32'd0);

    chk("strobes_left_a", 32'(sq_a.size()), 32'd0);
    chk("strobes_left_b", 32'(sq_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
